// File: rtl/sync_filter_glitch_filter.sv
// glitch_filter: single-channel stability filter with registered edge pulses
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : synchronised raw level
//   data_out   : filtered level (RESET_VALUE under reset)
//   rise, fall : one-cycle pulses in the first cycle data_out shows its new level
module glitch_filter #(
   parameter int   FILTER_CYCLES = 4,
   parameter logic RESET_VALUE   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic data_out,
   output logic rise,
   output logic fall
);
   localparam int CW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
   logic [CW-1:0] cnt;
   logic          accept;
   assign accept = (din != data_out) && (cnt == CW'(FILTER_CYCLES - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         data_out <= RESET_VALUE;
         rise     <= 1'b0;
         fall     <= 1'b0;
      end else begin
         // any agreeing cycle restarts the count, so only consecutive disagreement is accepted
         cnt  <= (din == data_out || accept) ? '0 : cnt + 1'b1;
         rise <= accept & din;
         fall <= accept & ~din;
         if (accept) data_out <= din;
      end
   end
endmodule

// File: rtl/sync_filter.sv
// sync_filter: multi-channel input conditioner (synchroniser + glitch filter + edge pulses)
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : asynchronous raw inputs [WIDTH]
//   sync_raw   : last synchroniser stage [WIDTH]
//   data_out   : filtered levels [WIDTH]
//   rise, fall : one-cycle edge pulses of data_out [WIDTH]
module sync_filter #(
   parameter int               WIDTH         = 1,
   parameter int               STAGES        = 2,
   parameter int               FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] sync_raw,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] s;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s <= {STAGES{RESET_VALUE}};
      else        s <= {s[STAGES-2:0], data_in};
   end
   assign sync_raw = s[STAGES-1];
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      glitch_filter #(
         .FILTER_CYCLES(FILTER_CYCLES),
         .RESET_VALUE  (RESET_VALUE[i])
      ) u_gf (
         .clk     (clk),
         .rst_n   (rst_n),
         .din     (sync_raw[i]),
         .data_out(data_out[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end
endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed self-checking bench for sync_filter (default and corner parameter sets)
module tb_sync_filter;
   logic       clk = 1'b0;
   logic       rst_n_a, rst_n_b;
   logic [3:0] data_in_a, data_in_b;
   logic [3:0] sync_raw_a, data_out_a, rise_a, fall_a;
   logic [3:0] sync_raw_b, data_out_b, rise_b, fall_b;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(4), .RESET_VALUE(4'h0)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .data_in(data_in_a), .sync_raw(sync_raw_a),
      .data_out(data_out_a), .rise(rise_a), .fall(fall_a));

   sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VALUE(4'hA)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .data_in(data_in_b), .sync_raw(sync_raw_b),
      .data_out(data_out_b), .rise(rise_b), .fall(fall_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int k, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
      check($sformatf("%s_out_k%0d", tag, k), data_out_a, o);
      check($sformatf("%s_rise_k%0d", tag, k), rise_a, r);
      check($sformatf("%s_fall_k%0d", tag, k), fall_a, f);
   endtask

   task automatic chk_b(input string tag, input int k, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
      check($sformatf("%s_out_k%0d", tag, k), data_out_b, o);
      check($sformatf("%s_rise_k%0d", tag, k), rise_b, r);
      check($sformatf("%s_fall_k%0d", tag, k), fall_b, f);
   endtask

   task automatic settle_a(input logic [3:0] v);
      data_in_a = v;
      repeat (12) @(negedge clk);
      chk_a("settle", 0, v, 4'h0, 4'h0);
   endtask

   initial begin
      rst_n_a   = 1'b0;
      rst_n_b   = 1'b0;
      data_in_a = 4'hF;
      data_in_b = 4'hA;
      // reset held with inputs high: nothing propagates
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk_a("rst", k, 4'h0, 4'h0, 4'h0);
         check($sformatf("rst_sync_k%0d", k), sync_raw_a, 4'h0);
         chk_b("rstb", k, 4'hA, 4'h0, 4'h0);
         check($sformatf("rstb_sync_k%0d", k), sync_raw_b, 4'hA);
      end
      // release: F appears after 6 edges with one rise pulse
      rst_n_a = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("rel_sync_k%0d", k), sync_raw_a, k >= 2 ? 4'hF : 4'h0);
         chk_a("rel", k, k >= 6 ? 4'hF : 4'h0, k == 6 ? 4'hF : 4'h0, 4'h0);
      end
      // step bit0 with bit3 held high
      settle_a(4'h8);
      data_in_a = 4'h9;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("step_sync_k%0d", k), sync_raw_a, k >= 2 ? 4'h9 : 4'h8);
         chk_a("step", k, k >= 6 ? 4'h9 : 4'h8, k == 6 ? 4'h1 : 4'h0, 4'h0);
      end
      // bit1 high for 3 cycles: rejected
      for (int k = 1; k <= 12; k++) begin
         data_in_a = k <= 3 ? 4'hB : 4'h9;
         @(negedge clk);
         chk_a("glitch3", k, 4'h9, 4'h0, 4'h0);
      end
      // bit1 high for 4 cycles: accepted, rise then fall 4 cycles apart
      for (int k = 1; k <= 11; k++) begin
         data_in_a = k <= 4 ? 4'hB : 4'h9;
         @(negedge clk);
         chk_a("glitch4", k, (k >= 6 && k < 10) ? 4'hB : 4'h9, k == 6 ? 4'h2 : 4'h0, k == 10 ? 4'h2 : 4'h0);
      end
      // restart: bit0 high 3, low 1, high again; accept 4 cycles after the second rise
      settle_a(4'h8);
      for (int k = 1; k <= 12; k++) begin
         data_in_a = k == 4 ? 4'h8 : 4'h9;
         @(negedge clk);
         chk_a("restart", k, k >= 10 ? 4'h9 : 4'h8, k == 10 ? 4'h1 : 4'h0, 4'h0);
      end
      // reset mid-filter: bit0 falling, counter at 2 after edge 4
      data_in_a = 4'h8;
      repeat (4) @(negedge clk);
      chk_a("midf_pre", 0, 4'h9, 4'h0, 4'h0);
      #2 rst_n_a = 1'b0;
      #1;
      chk_a("midf_rst", 0, 4'h0, 4'h0, 4'h0);
      check("midf_rst_sync", sync_raw_a, 4'h0);
      repeat (2) @(negedge clk);
      rst_n_a = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk_a("midf_rel", k, k >= 6 ? 4'h8 : 4'h0, k == 6 ? 4'h8 : 4'h0, 4'h0);
      end
      // corner set: STAGES=3, FILTER_CYCLES=1, RESET_VALUE=A
      rst_n_b = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk_b("brel", k, 4'hA, 4'h0, 4'h0);
      end
      data_in_b = 4'hB;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk_b("bstep", k, k >= 4 ? 4'hB : 4'hA, k == 4 ? 4'h1 : 4'h0, 4'h0);
      end
      data_in_b = 4'h7;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk_b("bsim", k, k >= 4 ? 4'h7 : 4'hB, k == 4 ? 4'h4 : 4'h0, k == 4 ? 4'h8 : 4'h0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
